alu_op_sequencer: RTL and testbench

- Hardware control-step sequencer for register-register ALU instructions on the single-bus data_path; replaces hand-sequenced bench control.
- On a start request it drives the bus-out/bus-in strobes (register one-hot vectors, Yin, Zhighin/Zlowin, Zlowout/Zhighout, alu_op) through fixed T-steps, with optional HI write-back for wide ops.
- Sits between the instruction decode/control unit and data_path.
- Generalised over register count and op width, with a start/busy/done handshake.

---
 rtl/alu_seq_pkg.sv | 42 ++++
 rtl/onehot_dec.sv | 22 ++
 rtl/alu_op_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU op sequencer: op encodings, FSM states and
// op-class helpers used by the control logic.
package alu_seq_pkg;

    localparam int unsigned OP_BITS = 5;

    typedef logic [OP_BITS-1:0] op_t;

    localparam op_t OP_ADD           = 5'b00000;
    localparam op_t OP_SUB           = 5'b00001;
    localparam op_t OP_OR            = 5'b00010;
    localparam op_t OP_AND           = 5'b00011;
    localparam op_t OP_SHR           = 5'b00100;
    localparam op_t OP_SHL           = 5'b00101;
    localparam op_t OP_ROR           = 5'b00110;
    localparam op_t OP_ROL           = 5'b00111;
    localparam op_t OP_MUL           = 5'b01000;
    localparam op_t OP_DIV           = 5'b01001;
    localparam op_t OP_NEG           = 5'b01010;
    localparam op_t OP_NOT           = 5'b01011;
    localparam op_t OP_FIRST_ILLEGAL = 5'b01100;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_Y,
        EXEC,
        WB_LO,
        WB_HI,
        DONE
    } state_t;

    // Ops that produce a result in Z high as well as Z low.
    function automatic logic is_wide(input op_t op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

    // Ops with a single source operand; they skip the Y load.
    function automatic logic is_unary(input op_t op);
        return (op == OP_NEG) || (op == OP_NOT);
    endfunction

endpackage

// File: rtl/onehot_dec.sv
// Index to one-hot decoder with enable.
//   idx      : register index
//   en       : decoder enable; all zeros when low
//   onehot_c : combinational one-hot vector, N bits
module onehot_dec #(
    parameter int unsigned N = 16,
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] idx,
    input  logic         en,
    output logic [N-1:0] onehot_c
);

    // Out-of-range indices (non-power-of-two N) decode to all zeros.
    always_comb begin
        onehot_c = '0;
        for (int i = 0; i < N; i++) begin
            onehot_c[i] = en && (idx == W'(i));
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Control-step sequencer for register-register ALU instructions on the
// single-bus data path. A start request latches op/operands and steps through
// LOAD_Y, EXEC, WB_LO, optional WB_HI, DONE, driving one-cycle strobes.
//   Clock, clear           : clock, async active-high reset
//   start, op, ra..rhi     : request and latched instruction fields
//   Rout, Rin              : one-hot register drive / load strobes
//   Yin, Zlowin, Zhighin,
//   Zlowout, Zhighout      : data path strobes
//   alu_op                 : op presented to the ALU during EXEC only
//   busy, done, err        : handshake; done/err are one-cycle pulses
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned REG_W    = $clog2(NUM_REGS),
    parameter int unsigned OP_W     = 5
) (
    input  logic                Clock,
    input  logic                clear,
    input  logic                start,
    input  logic [OP_W-1:0]     op,
    input  logic [REG_W-1:0]    ra,
    input  logic [REG_W-1:0]    rb,
    input  logic [REG_W-1:0]    rc,
    input  logic [REG_W-1:0]    rhi,
    output logic [NUM_REGS-1:0] Rout,
    output logic [NUM_REGS-1:0] Rin,
    output logic                Yin,
    output logic                Zlowin,
    output logic                Zhighin,
    output logic                Zlowout,
    output logic                Zhighout,
    output logic [OP_W-1:0]     alu_op,
    output logic                busy,
    output logic                done,
    output logic                err
);

    state_t             state;
    state_t             state_nxt;

    logic [OP_W-1:0]    op_q;
    logic [REG_W-1:0]   ra_q;
    logic [REG_W-1:0]   rb_q;
    logic [REG_W-1:0]   rc_q;
    logic [REG_W-1:0]   rhi_q;

    logic               accept_c;
    logic [OP_W-1:0]    op_sel_c;
    logic [REG_W-1:0]   ra_sel_c;
    logic [REG_W-1:0]   rb_sel_c;
    logic [REG_W-1:0]   rc_sel_c;
    logic [REG_W-1:0]   rhi_sel_c;
    logic               illegal_c;
    logic               unary_c;
    logic               wide_c;

    logic               rout_en_c;
    logic [REG_W-1:0]   rout_idx_c;
    logic               rin_en_c;
    logic [REG_W-1:0]   rin_idx_c;
    logic [NUM_REGS-1:0] rout_nxt_c;
    logic [NUM_REGS-1:0] rin_nxt_c;

    logic               yin_nxt;
    logic               zlowin_nxt;
    logic               zhighin_nxt;
    logic               zlowout_nxt;
    logic               zhighout_nxt;
    logic [OP_W-1:0]    alu_op_nxt;
    logic               busy_nxt;
    logic               done_nxt;
    logic               err_nxt;

    onehot_dec #(.N(NUM_REGS), .W(REG_W)) u_rout_dec (
        .idx      (rout_idx_c),
        .en       (rout_en_c),
        .onehot_c (rout_nxt_c)
    );

    onehot_dec #(.N(NUM_REGS), .W(REG_W)) u_rin_dec (
        .idx      (rin_idx_c),
        .en       (rin_en_c),
        .onehot_c (rin_nxt_c)
    );

    // Next state and next output values. Outputs are decoded from the state
    // being entered so they are registered alongside it; on the accepting
    // edge the live inputs are used because the latches are loaded that edge.
    always_comb begin
        state_nxt    = state;
        rout_en_c    = 1'b0;
        rout_idx_c   = '0;
        rin_en_c     = 1'b0;
        rin_idx_c    = '0;
        yin_nxt      = 1'b0;
        zlowin_nxt   = 1'b0;
        zhighin_nxt  = 1'b0;
        zlowout_nxt  = 1'b0;
        zhighout_nxt = 1'b0;
        alu_op_nxt   = '0;
        busy_nxt     = 1'b0;
        done_nxt     = 1'b0;
        err_nxt      = 1'b0;

        accept_c  = (state == IDLE) && start;
        op_sel_c  = accept_c ? op  : op_q;
        ra_sel_c  = accept_c ? ra  : ra_q;
        rb_sel_c  = accept_c ? rb  : rb_q;
        rc_sel_c  = accept_c ? rc  : rc_q;
        rhi_sel_c = accept_c ? rhi : rhi_q;
        illegal_c = (op_sel_c >= OP_W'(OP_FIRST_ILLEGAL));
        unary_c   = !illegal_c && is_unary(OP_BITS'(op_sel_c));
        wide_c    = !illegal_c && is_wide(OP_BITS'(op_sel_c));

        case (state)
            IDLE: begin
                if (start) begin
                    if (illegal_c) begin
                        state_nxt = DONE;
                        err_nxt   = 1'b1;
                    end else if (unary_c) begin
                        state_nxt = EXEC;
                    end else begin
                        state_nxt = LOAD_Y;
                    end
                end
            end
            LOAD_Y:  state_nxt = EXEC;
            EXEC:    state_nxt = WB_LO;
            WB_LO:   state_nxt = wide_c ? WB_HI : DONE;
            WB_HI:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        case (state_nxt)
            LOAD_Y: begin
                rout_en_c  = 1'b1;
                rout_idx_c = rb_sel_c;
                yin_nxt    = 1'b1;
                busy_nxt   = 1'b1;
            end
            EXEC: begin
                rout_en_c   = 1'b1;
                rout_idx_c  = unary_c ? rb_sel_c : rc_sel_c;
                alu_op_nxt  = op_sel_c;
                zlowin_nxt  = 1'b1;
                zhighin_nxt = 1'b1;
                busy_nxt    = 1'b1;
            end
            WB_LO: begin
                rin_en_c    = 1'b1;
                rin_idx_c   = ra_sel_c;
                zlowout_nxt = 1'b1;
                busy_nxt    = 1'b1;
            end
            WB_HI: begin
                rin_en_c     = 1'b1;
                rin_idx_c    = rhi_sel_c;
                zhighout_nxt = 1'b1;
                busy_nxt     = 1'b1;
            end
            DONE:    done_nxt = 1'b1;
            default: ;
        endcase
    end

    // State, operand latches and registered outputs.
    always_ff @(posedge Clock or posedge clear) begin
        if (clear) begin
            state    <= IDLE;
            op_q     <= '0;
            ra_q     <= '0;
            rb_q     <= '0;
            rc_q     <= '0;
            rhi_q    <= '0;
            Rout     <= '0;
            Rin      <= '0;
            Yin      <= 1'b0;
            Zlowin   <= 1'b0;
            Zhighin  <= 1'b0;
            Zlowout  <= 1'b0;
            Zhighout <= 1'b0;
            alu_op   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            if (accept_c) begin
                op_q  <= op;
                ra_q  <= ra;
                rb_q  <= rb;
                rc_q  <= rc;
                rhi_q <= rhi;
            end
            Rout     <= rout_nxt_c;
            Rin      <= rin_nxt_c;
            Yin      <= yin_nxt;
            Zlowin   <= zlowin_nxt;
            Zhighin  <= zhighin_nxt;
            Zlowout  <= zlowout_nxt;
            Zhighout <= zhighout_nxt;
            alu_op   <= alu_op_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            err      <= err_nxt;
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: directed scenarios followed by
// randomized requests, compared every cycle against a transaction-level model
// that expands each accepted request into its expected per-cycle output frames.
module tb_alu_op_sequencer;

    localparam int unsigned NUM_REGS = 16;
    localparam int unsigned REG_W    = 4;
    localparam int unsigned OP_W     = 5;

    logic                Clock;
    logic                clear;
    logic                start;
    logic [OP_W-1:0]     op;
    logic [REG_W-1:0]    ra, rb, rc, rhi;
    logic [NUM_REGS-1:0] Rout, Rin;
    logic                Yin, Zlowin, Zhighin, Zlowout, Zhighout;
    logic [OP_W-1:0]     alu_op;
    logic                busy, done, err;

    alu_op_sequencer #(.NUM_REGS(NUM_REGS), .REG_W(REG_W), .OP_W(OP_W)) dut (
        .Clock    (Clock),
        .clear    (clear),
        .start    (start),
        .op       (op),
        .ra       (ra),
        .rb       (rb),
        .rc       (rc),
        .rhi      (rhi),
        .Rout     (Rout),
        .Rin      (Rin),
        .Yin      (Yin),
        .Zlowin   (Zlowin),
        .Zhighin  (Zhighin),
        .Zlowout  (Zlowout),
        .Zhighout (Zhighout),
        .alu_op   (alu_op),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // One expected output cycle. strb = {Yin, Zlowin, Zhighin, Zlowout, Zhighout},
    // bde = {busy, done, err}.
    typedef struct packed {
        logic [15:0] rout;
        logic [15:0] rin;
        logic [4:0]  strb;
        logic [4:0]  aop;
        logic [2:0]  bde;
    } frame_t;

    frame_t q[$];
    frame_t cur;
    int     n_chk;
    int     n_err;
    int     cyc;
    int     acc_cyc;
    int     want_lat;
    int     last_done;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got=%0h want=%0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    function automatic frame_t mk(input logic [15:0] rout, input logic [15:0] rin,
                                  input logic [4:0] strb, input logic [4:0] aop,
                                  input logic [2:0] bde);
        frame_t f;
        f.rout = rout; f.rin = rin; f.strb = strb; f.aop = aop; f.bde = bde;
        return f;
    endfunction

    // Expand one accepted request into the cycles that follow the accepting edge.
    task automatic enqueue(input logic [4:0] o, input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] c, input logic [3:0] h);
        logic unary, wide;
        unary = (o == 5'd10) || (o == 5'd11);
        wide  = (o == 5'd8)  || (o == 5'd9);
        if (o >= 5'd12) begin
            q.push_back(mk(16'h0, 16'h0, 5'b00000, 5'd0, 3'b011));
        end else begin
            if (!unary) q.push_back(mk(16'(1) << b, 16'h0, 5'b10000, 5'd0, 3'b100));
            q.push_back(mk(16'(1) << (unary ? b : c), 16'h0, 5'b01100, o, 3'b100));
            q.push_back(mk(16'h0, 16'(1) << a, 5'b00010, 5'd0, 3'b100));
            if (wide) q.push_back(mk(16'h0, 16'(1) << h, 5'b00001, 5'd0, 3'b100));
            q.push_back(mk(16'h0, 16'h0, 5'b00000, 5'd0, 3'b010));
        end
    endtask

    task automatic compare_outputs();
        check("rout",   32'(Rout), 32'(cur.rout));
        check("rin",    32'(Rin),  32'(cur.rin));
        check("strobes", 32'({Yin, Zlowin, Zhighin, Zlowout, Zhighout}), 32'(cur.strb));
        check("alu_op", 32'(alu_op), 32'(cur.aop));
        check("busy_done_err", 32'({busy, done, err}), 32'(cur.bde));
    endtask

    // Advance one clock: update the model from the inputs seen at the edge,
    // then sample the DUT 1 time unit later.
    task automatic step();
        @(posedge Clock);
        cyc++;
        if (clear) begin
            q.delete();
            cur = '0;
        end else begin
            if (q.size() == 0 && !cur.bde[1] && start) begin
                enqueue(op, ra, rb, rc, rhi);
                acc_cyc  = cyc;
                want_lat = (op >= 5'd12) ? 1 :
                           (op == 5'd8 || op == 5'd9) ? 5 :
                           (op == 5'd10 || op == 5'd11) ? 3 : 4;
            end
            if (q.size() > 0) cur = q.pop_front();
            else              cur = '0;
        end
        #1;
        compare_outputs();
        if (done) begin
            check("latency", 32'(cyc - acc_cyc + 1), 32'(want_lat));
            last_done = cyc;
        end
    endtask

    task automatic set_in(input logic s, input logic [4:0] o, input logic [3:0] a,
                          input logic [3:0] b, input logic [3:0] c, input logic [3:0] h);
        start = s; op = o; ra = a; rb = b; rc = c; rhi = h;
    endtask

    // Assert clear mid-cycle; outputs must drop before the next edge.
    task automatic async_clear();
        #2;
        clear = 1'b1;
        #1;
        q.delete();
        cur = '0;
        compare_outputs();
        step();
        clear = 1'b0;
    endtask

    initial begin
        int d1, d2;
        n_chk = 0; n_err = 0; cyc = 0; acc_cyc = 0; want_lat = 0; last_done = 0;
        cur = '0;
        clear = 1'b0;
        set_in(1'b0, 5'd0, 4'd0, 4'd0, 4'd0, 4'd0);
        #1 clear = 1'b1;
        #1 compare_outputs();
        step();
        step();
        clear = 1'b0;
        step();

        // OR r1 = r2 | r3
        set_in(1'b1, 5'b00010, 4'd1, 4'd2, 4'd3, 4'd0);
        step();
        check("or_c1_rout", 32'(Rout), 32'h0004);
        start = 1'b0;
        step();
        check("or_c2_alu_op", 32'(alu_op), 32'h02);
        step();
        check("or_c3_rin", 32'(Rin), 32'h0002);
        step();
        check("or_c4_done", 32'(done), 32'h1);
        step();

        // MUL with HI write-back
        set_in(1'b1, 5'b01000, 4'd6, 4'd4, 4'd5, 4'd7);
        step();
        start = 1'b0;
        for (int i = 0; i < 6; i++) step();

        // NOT: unary path skips Y load
        set_in(1'b1, 5'b01011, 4'd10, 4'd9, 4'd0, 4'd0);
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) step();

        // Back-to-back: held ADD start, SUB pulse while busy is ignored
        set_in(1'b1, 5'b00000, 4'd1, 4'd2, 4'd3, 4'd4);
        d1 = 0; d2 = 0;
        for (int i = 0; i < 14; i++) begin
            if (i == 1) set_in(1'b1, 5'b00001, 4'd8, 4'd9, 4'd10, 4'd11);
            if (i == 2) set_in(1'b1, 5'b00000, 4'd1, 4'd2, 4'd3, 4'd4);
            step();
            if (done && d1 == 0)                d1 = cyc;
            else if (done && d2 == 0 && d1 != 0) d2 = cyc;
        end
        check("b2b_gap", 32'(d2 - d1), 32'd5);
        start = 1'b0;
        for (int i = 0; i < 6; i++) step();

        // Illegal op
        set_in(1'b1, 5'b01111, 4'd1, 4'd2, 4'd3, 4'd4);
        step();
        check("illegal_err", 32'({done, err}), 32'h3);
        start = 1'b0;
        for (int i = 0; i < 3; i++) step();

        // Clear during EXEC of a DIV, then a normal run
        set_in(1'b1, 5'b01001, 4'd1, 4'd2, 4'd3, 4'd4);
        step();
        start = 1'b0;
        step();
        async_clear();
        for (int i = 0; i < 6; i++) step();
        set_in(1'b1, 5'b00011, 4'd5, 4'd6, 4'd7, 4'd0);
        step();
        start = 1'b0;
        for (int i = 0; i < 5; i++) step();

        // Randomized requests with occasional asynchronous clears
        for (int i = 0; i < 3000; i++) begin
            set_in(1'($urandom_range(0, 1)),
                   ($urandom_range(0, 4) == 0) ? 5'($urandom_range(12, 31))
                                               : 5'($urandom_range(0, 11)),
                   4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
            if ($urandom_range(0, 299) == 0) async_clear();
            else                             step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
